// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the SPI frame controller.
package spi_frame_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Number of SPI clocks in one complete frame: rw bit, address, data.
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a delay
// flop so single-cycle rise/fall pulses can be produced in the clk domain.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Shift the pin through the synchroniser chain and keep one delayed copy.
  // NOTE: reset is sampled on the clock edge (synchronous) and all state
  // updates use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else if (ena) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~dly_q;
  assign fall_o = ~q_o & dly_q;

endmodule

// File: rtl/spi_frame_controller.sv
// SPI mode-0 slave frame sequencer: {rw, addr, data} MSB first, producing
// single-cycle register read/write strobes and shifting read data on MISO.
module spi_frame_controller
  import spi_frame_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W);

  // Synchronised pin levels and edges.
  logic cs_lvl_unused, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rstb(rstb), .ena(ena), .d_i(spi_cs_n),
    .q_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rstb(rstb), .ena(ena), .d_i(spi_sclk),
    .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rstb(rstb), .ena(ena), .d_i(spi_mosi),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  // Frame state.
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                reg_re_q, reg_re_d;
  logic                reg_we_q, reg_we_d;
  logic                we_pend_q, we_pend_d;
  logic                tx_load_q, tx_load_d;
  logic                frame_err_q, frame_err_d;

  // Field values including the bit arriving on this rise.
  logic [ADDR_W-1:0] addr_full;
  logic [DATA_W-1:0] rx_full;
  assign addr_full = ADDR_W'({addr_sh_q, mosi_s});
  assign rx_full   = DATA_W'({rx_sh_q, mosi_s});

  // Next-state and datapath decode; cs_rise takes priority over sclk edges.
  // NOTE: every _d signal receives a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rw_d        = rw_q;
    addr_sh_d   = addr_sh_q;
    reg_addr_d  = reg_addr_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    reg_re_d    = 1'b0;
    we_pend_d   = 1'b0;
    frame_err_d = 1'b0;
    tx_load_d   = reg_re_q;
    reg_we_d    = we_pend_q;
    reg_wdata_d = we_pend_q ? rx_sh_q : reg_wdata_q;

    // Read data is captured the cycle after the read strobe.
    if (tx_load_q) tx_sh_d = reg_rdata;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end
      end
      ST_CMD: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          rw_d      = mosi_s;
          state_d   = ST_ADDR;
          bit_cnt_d = '0;
        end
      end
      ST_ADDR: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          addr_sh_d = addr_full;
          if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
            reg_addr_d = addr_full;
            reg_re_d   = rw_q;
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          rx_sh_d = rx_full;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d   = ST_DONE;
            we_pend_d = ~rw_q;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall && (bit_cnt_q != '0) && rw_q) begin
          // The first fall after the address keeps the MSB on the line.
          tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        end
      end
      ST_DONE: begin
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; everything holds while ena is low.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rw_q        <= 1'b0;
      addr_sh_q   <= '0;
      reg_addr_q  <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      reg_wdata_q <= '0;
      reg_re_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      we_pend_q   <= 1'b0;
      tx_load_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rw_q        <= rw_d;
      addr_sh_q   <= addr_sh_d;
      reg_addr_q  <= reg_addr_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      reg_wdata_q <= reg_wdata_d;
      reg_re_q    <= reg_re_d;
      reg_we_q    <= reg_we_d;
      we_pend_q   <= we_pend_d;
      tx_load_q   <= tx_load_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi_miso  = (state_q == ST_DATA) && rw_q && tx_sh_q[DATA_W-1];
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q & ena;
  assign reg_re    = reg_re_q & ena;
  assign frame_err = frame_err_q & ena;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/spi_frame_controller.md
Name: spi_frame_controller

Overview:
SPI mode-0 slave frame sequencer for the register-file interface. Synchronises the raw spi_cs_n, spi_sclk and spi_mosi pins into the clk domain and detects their edges. Runs a frame state machine over the fixed frame format {rw, addr[ADDR_W-1:0], data[DATA_W-1:0]}, all fields MSB first. It issues single-cycle register write/read strobes and shifts read data out on spi_miso.

Parameters:
ADDR_W, 3, register address width in bits (>=1)
DATA_W, 8, register data width in bits (>=2)
SYNC_STAGES, 2, synchroniser flops per SPI input (>=2)

Ports:
clk  in  1  system clock; must be >= 8x the spi_sclk frequency
rstb  in  1  reset, synchronous, active-low
ena  in  1  block enable; when 0 all flops hold and strobes are forced to 0
spi_cs_n  in  1  raw chip select, active-low, asynchronous
spi_sclk  in  1  raw SPI clock, asynchronous
spi_mosi  in  1  raw SPI data in, asynchronous
spi_miso  out  1  SPI data out
reg_addr  out  ADDR_W  address of the current/last access
reg_wdata  out  DATA_W  write data; valid while reg_we=1
reg_we  out  1  single-cycle write strobe
reg_re  out  1  single-cycle read strobe
reg_rdata  in  DATA_W  read data; must be valid the cycle after reg_re
busy  out  1  1 when the state is not IDLE
frame_err  out  1  single-cycle pulse when a frame is aborted

Behaviour:
- Reset (rstb=0 at a clk edge): state IDLE, counters 0. Synchroniser outputs: cs=1, sclk=0, mosi=0. Delay flops match. All outputs 0.
- Synchroniser: SYNC_STAGES flops per input, followed by a delay flop.
- sclk_rise = s & !s_dly; sclk_fall = !s & s_dly; cs_fall and cs_rise are derived the same way from cs.
- Edge-to-action latency is SYNC_STAGES+1 clk cycles.
- States: IDLE, CMD, ADDR, DATA, DONE.
- IDLE: on cs_fall, go to CMD and clear bit_cnt.
- CMD: on sclk_rise, rw <= mosi; go to ADDR with bit_cnt=0.
- ADDR: on each sclk_rise, shift mosi into the addr shift register and increment bit_cnt.
  - On the rise with bit_cnt==ADDR_W-1: reg_addr takes the full address and the state moves to DATA with bit_cnt=0.
  - If rw=1, reg_re pulses 1 cycle later (registered).
  - tx_shift <= reg_rdata on the cycle after reg_re.
- DATA: on each sclk_rise, shift mosi into rx_shift and increment bit_cnt.
  - On each sclk_fall with bit_cnt!=0 and rw=1, shift tx_shift left.
  - The first fall after the address phase does not shift, so the MSB is held for the first data rise.
  - On the rise with bit_cnt==DATA_W-1, go to DONE.
  - If rw=0, on the next cycle reg_wdata <= full word and reg_we=1 for exactly 1 cycle.
- DONE: all sclk edges are ignored; on cs_rise go to IDLE with no error.
- spi_miso = tx_shift[DATA_W-1] when state==DATA and rw=1; otherwise 0.
- reg_addr and reg_wdata hold their last values between frames.
- Abort: cs_rise in CMD, ADDR or DATA returns to IDLE, frame_err=1 for 1 cycle, and no reg_we is issued.
  - A reg_re already issued stands.
- cs_rise in the same cycle as sclk_rise or sclk_fall: cs_rise wins and the sclk edge is discarded.
- cs_fall while not IDLE cannot occur without a prior cs_rise; no special handling.
- Reset mid-frame: the state machine returns to IDLE. The remainder of the frame is ignored until a new cs_fall.
- ena=0: synchroniser and edge flops hold, so edges spanning ena=0 may be lost. The state is unchanged.
- bit_cnt width is $clog2(max(ADDR_W,DATA_W)); it never wraps within a field.

Decomposition:
- Package spi_frame_pkg: state enum typedef (IDLE, CMD, ADDR, DATA, DONE) and the frame-length function 1+ADDR_W+DATA_W.
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser, delay flop, and rise/fall outputs. It takes clk, rstb, ena and a parameter reset value. It is instantiated three times: for cs (reset 1), sclk (reset 0) and mosi (reset 0; edges unused).

Test Plan:
1. Write frame: rw=0, addr=3'b101, data=0xA5, sclk=clk/16 -> exactly one reg_we with reg_addr=5 and reg_wdata=0xA5; reg_re never asserted; frame_err=0; busy returns to 0 after cs_n rises.
2. Read frame: rw=1, addr=3'b010, reg_rdata=0x3C -> one reg_re with reg_addr=2. spi_miso sampled at the 8 data rises = 0,0,1,1,1,1,0,0. No reg_we.
3. Abort: cs_n rises after 6 bits (rw, addr, 2 data bits) -> frame_err pulses once, no reg_we, busy=0, reg_wdata unchanged.
4. Extra clocks: 14 sclk pulses with data 0x5A followed by junk -> a single reg_we with 0x5A; the extra rises are ignored in DONE.
5. Reset mid-frame: rstb low for 2 clk during ADDR -> all outputs 0. A following complete write (addr 1, data 0xFF) gives reg_we, addr 1, 0xFF.
6. cs_rise coincident with the last data sclk_rise -> treated as an abort: frame_err=1, no reg_we.
